// File: rtl/decode_define.sv
// Decode-stage types: ALU op, branch kind, memory sizes and the ID/EX control bundle.
package decode_define;

  import mips64_opcodes::*;

  typedef enum logic [4:0] {
    AluAdd, AluAddu, AluSub, AluSubu, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu,
    AluSll, AluSrl, AluSra, AluLsa, AluDadd, AluDaddu, AluDsub, AluDsll, AluDsrl, AluDsra,
    AluLui, AluPass
  } alu_op_t;

  typedef enum logic [2:0] {
    BrNone, BrBeq, BrBne, BrJ, BrJal, BrJr, BrBal, BrBc
  } branch_t;

  localparam logic [1:0] MemByte  = 2'd0;
  localparam logic [1:0] MemWord  = 2'd2;
  localparam logic [1:0] MemDword = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic [5:0] shamt;
    alu_op_t    alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_unsigned;
    logic [1:0] mem_size;
    branch_t    branch;
    logic       syscall;
    logic       eret;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips64_opcodes.sv
// Shared MIPS64 opcode constants: primary op, SPECIAL funct and REGIMM rt sub-opcodes.
package mips64_opcodes;

  // Primary opcode field, inst[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_Z0      = 6'h10;
  localparam logic [5:0] OP_DADDI   = 6'h18;
  localparam logic [5:0] OP_DADDIU  = 6'h19;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LWU     = 6'h27;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_BC      = 6'h32;
  localparam logic [5:0] OP_LD      = 6'h37;
  localparam logic [5:0] OP_SD      = 6'h3f;

  // SPECIAL funct field, inst[5:0]
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_LSA     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;
  localparam logic [5:0] FN_DADD    = 6'h2c;
  localparam logic [5:0] FN_DADDU   = 6'h2d;
  localparam logic [5:0] FN_DSUB    = 6'h2e;
  localparam logic [5:0] FN_DSLL    = 6'h38;
  localparam logic [5:0] FN_DSRL    = 6'h3a;
  localparam logic [5:0] FN_DSRA    = 6'h3b;
  localparam logic [5:0] FN_DSLL32  = 6'h3c;
  localparam logic [5:0] FN_DSRL32  = 6'h3e;

  // COP0 funct for ERET (with inst[25] set)
  localparam logic [5:0] FN_ERET    = 6'h18;

  // REGIMM rt sub-opcode: BAL is BGEZAL with rs=0
  localparam logic [4:0] RT_BAL     = 5'h11;

endpackage

// File: rtl/decode_ctrl.sv
// Purely combinational instruction decoder: inst -> control bundle, immediate, source usage.
module decode_ctrl
  import decode_define::*;
  import mips64_opcodes::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs,
  output logic            uses_rt
);

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, sa;
  logic [XLEN-1:0] imm_sext, imm_zext, imm_lui, imm_jidx, imm_bc;
  logic            legal;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign sa    = inst[10:6];
  assign funct = inst[5:0];

  assign imm_sext = {{(XLEN-16){inst[15]}}, inst[15:0]};
  assign imm_zext = {{(XLEN-16){1'b0}}, inst[15:0]};
  assign imm_lui  = {{(XLEN-32){inst[15]}}, inst[15:0], 16'h0000};
  assign imm_jidx = {{(XLEN-26){1'b0}}, inst[25:0]};
  assign imm_bc   = {{(XLEN-26){inst[25]}}, inst[25:0]};

  // Decode op/funct/rt into the control bundle; anything unknown collapses to illegal-only
  always_comb begin
    ctrl    = '0;
    imm     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    legal   = 1'b1;
    ctrl.rs = rs;
    ctrl.rt = rt;
    unique case (op)
      OP_SPECIAL: begin
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.dest      = rd;
        unique case (funct)
          FN_SLL:    begin ctrl.alu_op = AluSll;  ctrl.shamt = {1'b0, sa}; uses_rs = 1'b0; end
          FN_SRL:    begin ctrl.alu_op = AluSrl;  ctrl.shamt = {1'b0, sa}; uses_rs = 1'b0; end
          FN_SRA:    begin ctrl.alu_op = AluSra;  ctrl.shamt = {1'b0, sa}; uses_rs = 1'b0; end
          FN_DSLL:   begin ctrl.alu_op = AluDsll; ctrl.shamt = {1'b0, sa}; uses_rs = 1'b0; end
          FN_DSRL:   begin ctrl.alu_op = AluDsrl; ctrl.shamt = {1'b0, sa}; uses_rs = 1'b0; end
          FN_DSRA:   begin ctrl.alu_op = AluDsra; ctrl.shamt = {1'b0, sa}; uses_rs = 1'b0; end
          // The *32 forms shift by sa+32, i.e. set bit 5 of the shift amount
          FN_DSLL32: begin ctrl.alu_op = AluDsll; ctrl.shamt = {1'b1, sa}; uses_rs = 1'b0; end
          FN_DSRL32: begin ctrl.alu_op = AluDsrl; ctrl.shamt = {1'b1, sa}; uses_rs = 1'b0; end
          FN_LSA:    begin ctrl.alu_op = AluLsa;  ctrl.shamt = {1'b0, sa}; end
          FN_ADD:    ctrl.alu_op = AluAdd;
          FN_ADDU:   ctrl.alu_op = AluAddu;
          FN_SUB:    ctrl.alu_op = AluSub;
          FN_SUBU:   ctrl.alu_op = AluSubu;
          FN_AND:    ctrl.alu_op = AluAnd;
          FN_OR:     ctrl.alu_op = AluOr;
          FN_XOR:    ctrl.alu_op = AluXor;
          FN_NOR:    ctrl.alu_op = AluNor;
          FN_SLT:    ctrl.alu_op = AluSlt;
          FN_SLTU:   ctrl.alu_op = AluSltu;
          FN_DADD:   ctrl.alu_op = AluDadd;
          FN_DADDU:  ctrl.alu_op = AluDaddu;
          FN_DSUB:   ctrl.alu_op = AluDsub;
          FN_JR: begin
            ctrl.alu_op    = AluPass;
            ctrl.branch    = BrJr;
            ctrl.reg_write = 1'b0;
            ctrl.dest      = 5'd0;
            uses_rt        = 1'b0;
          end
          FN_SYSCALL: begin
            ctrl.syscall   = 1'b1;
            ctrl.reg_write = 1'b0;
            ctrl.dest      = 5'd0;
            uses_rs        = 1'b0;
            uses_rt        = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BAL) begin
          ctrl.alu_op    = AluPass;
          ctrl.branch    = BrBal;
          ctrl.reg_write = 1'b1;
          ctrl.dest      = 5'd31;
          imm            = imm_sext;
          uses_rs        = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_J: begin
        ctrl.branch = BrJ;
        imm         = imm_jidx;
      end
      OP_JAL: begin
        ctrl.alu_op    = AluPass;
        ctrl.branch    = BrJal;
        ctrl.reg_write = 1'b1;
        ctrl.dest      = 5'd31;
        imm            = imm_jidx;
      end
      OP_BC: begin
        ctrl.branch = BrBc;
        imm         = imm_bc;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op = AluSubu;
        ctrl.branch = (op == OP_BEQ) ? BrBeq : BrBne;
        imm         = imm_sext;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_DADDI, OP_DADDIU, OP_SLTI, OP_SLTIU: begin
        unique case (op)
          OP_ADDI:   ctrl.alu_op = AluAdd;
          OP_ADDIU:  ctrl.alu_op = AluAddu;
          OP_DADDI:  ctrl.alu_op = AluDadd;
          OP_DADDIU: ctrl.alu_op = AluDaddu;
          OP_SLTI:   ctrl.alu_op = AluSlt;
          default:   ctrl.alu_op = AluSltu;
        endcase
        ctrl.reg_write = 1'b1;
        ctrl.dest      = rt;
        imm            = imm_sext;
        uses_rs        = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        unique case (op)
          OP_ANDI: ctrl.alu_op = AluAnd;
          OP_ORI:  ctrl.alu_op = AluOr;
          default: ctrl.alu_op = AluXor;
        endcase
        ctrl.reg_write = 1'b1;
        ctrl.dest      = rt;
        imm            = imm_zext;
        uses_rs        = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op    = AluLui;
        ctrl.reg_write = 1'b1;
        ctrl.dest      = rt;
        imm            = imm_lui;
      end
      OP_LB, OP_LBU, OP_LW, OP_LWU, OP_LD: begin
        ctrl.alu_op       = AluDaddu;
        ctrl.reg_write    = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.dest         = rt;
        ctrl.mem_unsigned = (op == OP_LBU) || (op == OP_LWU);
        unique case (op)
          OP_LB, OP_LBU: ctrl.mem_size = MemByte;
          OP_LW, OP_LWU: ctrl.mem_size = MemWord;
          default:       ctrl.mem_size = MemDword;
        endcase
        imm     = imm_sext;
        uses_rs = 1'b1;
      end
      OP_SB, OP_SW, OP_SD: begin
        ctrl.alu_op    = AluDaddu;
        ctrl.mem_write = 1'b1;
        unique case (op)
          OP_SB:   ctrl.mem_size = MemByte;
          OP_SW:   ctrl.mem_size = MemWord;
          default: ctrl.mem_size = MemDword;
        endcase
        imm     = imm_sext;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_Z0: begin
        if (inst[25] && (funct == FN_ERET)) begin
          ctrl.eret = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase

    // Writes to r0 are discarded
    if (ctrl.dest == 5'd0) begin
      ctrl.reg_write = 1'b0;
    end

    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm          = '0;
      uses_rs      = 1'b0;
      uses_rt      = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS64 decode stage: valid/ready handshake, load-use bubble, flush and ID/EX register.
module decode_stage
  import decode_define::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dest,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_shamt,
  output logic [4:0]       out_alu_op,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_unsigned,
  output logic [1:0]       out_mem_size,
  output logic [2:0]       out_branch,
  output logic             out_syscall,
  output logic             out_eret,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t            dec_ctrl;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_uses_rs, dec_uses_rt;

  ctrl_t            ctrl_q;
  logic [XLEN-1:0]  imm_q, pc_q;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv, hazard, bubble, load;

  decode_ctrl #(
    .XLEN(XLEN)
  ) u_decode_ctrl (
    .inst    (in_inst),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt)
  );

  // Handshake, load-use detection and next-state selection in priority order
  always_comb begin
    adv    = ~valid_q | ex_ready;
    hazard = valid_q & ctrl_q.mem_read & (ctrl_q.dest != 5'd0) &
             ((dec_uses_rs & (dec_ctrl.rs == ctrl_q.dest)) |
              (dec_uses_rt & (dec_ctrl.rt == ctrl_q.dest)));
    in_ready = adv & ~hazard & ~flush;
    bubble   = ~flush & in_valid & hazard & ex_ready;
    load     = in_valid & in_ready;

    if (flush) begin
      valid_d = 1'b0;
    end else if (bubble) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    cnt_d = cnt_q;
    if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ID/EX output register and saturating bubble counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (load) begin
        ctrl_q <= dec_ctrl;
        imm_q  <= dec_imm;
        pc_q   <= in_pc;
      end
    end
  end

  assign out_valid        = valid_q;
  assign out_pc           = pc_q;
  assign out_rs           = ctrl_q.rs;
  assign out_rt           = ctrl_q.rt;
  assign out_dest         = ctrl_q.dest;
  assign out_imm          = imm_q;
  assign out_shamt        = ctrl_q.shamt;
  assign out_alu_op       = ctrl_q.alu_op;
  assign out_reg_write    = ctrl_q.reg_write;
  assign out_mem_read     = ctrl_q.mem_read;
  assign out_mem_write    = ctrl_q.mem_write;
  assign out_mem_unsigned = ctrl_q.mem_unsigned;
  assign out_mem_size     = ctrl_q.mem_size;
  assign out_branch       = ctrl_q.branch;
  assign out_syscall      = ctrl_q.syscall;
  assign out_eret         = ctrl_q.eret;
  assign out_illegal      = ctrl_q.illegal;
  assign stall_count      = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, load-use bubble, backpressure, flush, reset.
module tb_decode_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;

  localparam logic [31:0] I_ADDIU  = 32'h2465fffc; // addiu r5,r3,-4
  localparam logic [31:0] I_LD     = 32'hdc470000; // ld r7,0(r2)
  localparam logic [31:0] I_DADDU  = 32'h00e1402d; // daddu r8,r7,r1

  logic             clock, reset_n, in_valid, in_ready, flush, ex_ready, out_valid;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [4:0]       out_rs, out_rt, out_dest, out_alu_op;
  logic [5:0]       out_shamt;
  logic             out_reg_write, out_mem_read, out_mem_write, out_mem_unsigned;
  logic [1:0]       out_mem_size;
  logic [2:0]       out_branch;
  logic             out_syscall, out_eret, out_illegal;
  logic [CNT_W-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  decode_stage #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_inst          (in_inst),
    .in_pc            (in_pc),
    .flush            (flush),
    .ex_ready         (ex_ready),
    .out_valid        (out_valid),
    .out_pc           (out_pc),
    .out_rs           (out_rs),
    .out_rt           (out_rt),
    .out_dest         (out_dest),
    .out_imm          (out_imm),
    .out_shamt        (out_shamt),
    .out_alu_op       (out_alu_op),
    .out_reg_write    (out_reg_write),
    .out_mem_read     (out_mem_read),
    .out_mem_write    (out_mem_write),
    .out_mem_unsigned (out_mem_unsigned),
    .out_mem_size     (out_mem_size),
    .out_branch       (out_branch),
    .out_syscall      (out_syscall),
    .out_eret         (out_eret),
    .out_illegal      (out_illegal),
    .stall_count      (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single cycle (called at a falling edge, returns at the next)
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_inst  = '0;
    in_pc    = '0;
    flush    = 1'b0;
    ex_ready = 1'b0;
    #2;
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_stall", stall_count, 0);
    check_eq("reset_imm", out_imm, 0);
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    ex_ready = 1'b1;

    // ADDIU r5,r3,-4
    in_valid = 1'b1; in_inst = I_ADDIU; in_pc = 64'h1000;
    #1 check_eq("addiu_in_ready", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    check_eq("addiu_valid", out_valid, 1);
    check_eq("addiu_dest", out_dest, 5);
    check_eq("addiu_rs", out_rs, 3);
    check_eq("addiu_imm", out_imm, 64'hffff_ffff_ffff_fffc);
    check_eq("addiu_alu", out_alu_op, 1);
    check_eq("addiu_regw", out_reg_write, 1);
    check_eq("addiu_pc", out_pc, 64'h1000);

    // Load-use: LD r7 then DADDU reading r7
    issue(I_LD, 64'h1004);
    check_eq("ld_valid", out_valid, 1);
    check_eq("ld_memrd", out_mem_read, 1);
    check_eq("ld_size", out_mem_size, 3);
    check_eq("ld_dest", out_dest, 7);
    check_eq("ld_alu", out_alu_op, 15);
    in_valid = 1'b1; in_inst = I_DADDU; in_pc = 64'h1008;
    #1 check_eq("hazard_in_ready", in_ready, 0);
    @(negedge clock);
    check_eq("bubble_valid", out_valid, 0);
    check_eq("bubble_stall", stall_count, 1);
    #1 check_eq("post_bubble_ready", in_ready, 1);
    @(negedge clock);
    check_eq("daddu_valid", out_valid, 1);
    check_eq("daddu_pc", out_pc, 64'h1008);
    check_eq("daddu_dest", out_dest, 8);
    check_eq("daddu_alu", out_alu_op, 15);
    check_eq("daddu_stall", stall_count, 1);

    // Backpressure: EX stalls for three cycles with a new instruction waiting
    ex_ready = 1'b0; in_inst = I_ADDIU; in_pc = 64'h100c;
    #1 check_eq("bp_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_pc", out_pc, 64'h1008);
      check_eq("bp_dest", out_dest, 8);
      check_eq("bp_ready", in_ready, 0);
    end
    ex_ready = 1'b1;
    #1 check_eq("bp_release_ready", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    check_eq("bp_next_pc", out_pc, 64'h100c);
    check_eq("bp_next_dest", out_dest, 5);

    // Flush in the would-be bubble cycle
    issue(I_LD, 64'h2000);
    check_eq("ld2_memrd", out_mem_read, 1);
    in_valid = 1'b1; in_inst = I_DADDU; in_pc = 64'h2004; flush = 1'b1;
    #1 check_eq("flush_ready", in_ready, 0);
    @(negedge clock);
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_stall", stall_count, 1);
    flush = 1'b0;
    #1 check_eq("after_flush_ready", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    check_eq("after_flush_valid", out_valid, 1);
    check_eq("after_flush_pc", out_pc, 64'h2004);
    check_eq("after_flush_stall", stall_count, 1);

    // Illegal opcode 0x3b
    issue(32'hec000000, 64'h3000);
    check_eq("ill_valid", out_valid, 1);
    check_eq("ill_flag", out_illegal, 1);
    check_eq("ill_regw", out_reg_write, 0);
    check_eq("ill_memrd", out_mem_read, 0);
    check_eq("ill_memwr", out_mem_write, 0);
    check_eq("ill_branch", out_branch, 0);

    issue(32'h0000000c, 64'h3004);
    check_eq("syscall_flag", out_syscall, 1);
    check_eq("syscall_ill", out_illegal, 0);

    issue(32'h42000018, 64'h3008);
    check_eq("eret_flag", out_eret, 1);
    check_eq("eret_ill", out_illegal, 0);

    // lbu r4,8(r0)
    issue(32'h90040008, 64'h300c);
    check_eq("lbu_size", out_mem_size, 0);
    check_eq("lbu_unsigned", out_mem_unsigned, 1);
    check_eq("lbu_dest", out_dest, 4);
    check_eq("lbu_imm", out_imm, 64'h8);

    // sw r2,-16(r1)
    issue(32'hac22fff0, 64'h3010);
    check_eq("sw_memwr", out_mem_write, 1);
    check_eq("sw_regw", out_reg_write, 0);
    check_eq("sw_dest", out_dest, 0);
    check_eq("sw_size", out_mem_size, 2);
    check_eq("sw_imm", out_imm, 64'hffff_ffff_ffff_fff0);

    // ori r1,r0,0x8000 zero-extends
    issue(32'h34018000, 64'h3014);
    check_eq("ori_imm", out_imm, 64'h8000);
    check_eq("ori_dest", out_dest, 1);

    // lui r2,0x8000 sign-extends the shifted value
    issue(32'h3c028000, 64'h3018);
    check_eq("lui_imm", out_imm, 64'hffff_ffff_8000_0000);
    check_eq("lui_alu", out_alu_op, 20);

    // dsll32 r3,r4,1 -> shift by 33
    issue(32'h0004187c, 64'h301c);
    check_eq("dsll32_shamt", out_shamt, 33);
    check_eq("dsll32_alu", out_alu_op, 17);
    check_eq("dsll32_dest", out_dest, 3);

    // addu r0,r1,r2 -> write to r0 suppressed
    issue(32'h00220021, 64'h3020);
    check_eq("r0_regw", out_reg_write, 0);

    // jal 0x10
    issue(32'h0c000010, 64'h3024);
    check_eq("jal_branch", out_branch, 4);
    check_eq("jal_dest", out_dest, 31);
    check_eq("jal_regw", out_reg_write, 1);
    check_eq("jal_imm", out_imm, 64'h10);

    // Asynchronous reset mid-cycle while holding under backpressure
    ex_ready = 1'b0; in_valid = 1'b1; in_inst = I_ADDIU; in_pc = 64'h4000;
    @(negedge clock);
    check_eq("hold_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_stall", stall_count, 0);
    check_eq("async_rst_pc", out_pc, 0);
    check_eq("async_rst_dest", out_dest, 0);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n  = 1'b1;
    ex_ready = 1'b1;
    @(negedge clock);
    check_eq("post_rst_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
